// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multi-cycle controller.
// Opcodes, datapath select codes, FSM states and the strobe bundle.
package isa_pkg;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_HALT  = 1;
    localparam int unsigned OP_LOAD  = 2;
    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_CLEAR = 4;
    localparam int unsigned OP_SKIP  = 5;
    localparam int unsigned OP_JUMP  = 6;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ZERO = 2'b11;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_SKIP = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    // Opcode classes; every undefined encoding folds into K_ILL.
    typedef enum logic [2:0] {
        K_ADD   = 3'd0,
        K_HALT  = 3'd1,
        K_LOAD  = 3'd2,
        K_STORE = 3'd3,
        K_CLEAR = 3'd4,
        K_SKIP  = 3'd5,
        K_JUMP  = 3'd6,
        K_ILL   = 3'd7
    } op_e;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       illegal;
    } strobes_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle.
// master is the controller side, slave the datapath side.
interface multicycle_control_if #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                alu_zero;
    logic                mem_ready;
    logic                PCWrite;
    logic [1:0]          PCSrc;
    logic                IorD;
    logic                IRWrite;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrc;
    logic [1:0]          ALUOp;
    logic                MemRead;
    logic                MemWrite;
    logic                MemToReg;
    logic                halted;
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output PCWrite, PCSrc, IorD, IRWrite,
        output RegDst, RegWrite, ALUSrc, ALUOp,
        output MemRead, MemWrite, MemToReg,
        output halted, illegal, retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  PCWrite, PCSrc, IorD, IRWrite,
        input  RegDst, RegWrite, ALUSrc, ALUOp,
        input  MemRead, MemWrite, MemToReg,
        input  halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational strobe map for the multi-cycle controller.
// (state, opcode class, alu_zero, mem_ready) -> strobe bundle.
module ctrl_decode
    import isa_pkg::*;
(
    input  logic [2:0] state,
    input  op_e        kind,
    input  op_e        live_kind,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output strobes_t   st
);

    always_comb begin
        st = '0;
        unique case (1'b1)
            (state == S_FETCH): begin
                st.mem_read = 1'b1;
                if (mem_ready) begin
                    st.ir_write = 1'b1;
                    st.pc_write = 1'b1;
                    st.pc_src   = PC_INC;
                end
            end
            (state == S_DECODE): begin
                // Opcode is not latched yet, so look at the live value.
                st.illegal = (live_kind == K_ILL);
            end
            (state == S_EXEC): begin
                unique case (kind)
                    K_ADD: begin
                        st.alu_src = 1'b0;
                        st.alu_op  = ALU_ADD;
                    end
                    K_LOAD, K_STORE: begin
                        st.alu_src = 1'b1;
                        st.alu_op  = ALU_ADD;
                    end
                    K_CLEAR: st.alu_op = ALU_ZERO;
                    K_SKIP: begin
                        st.alu_op = ALU_SUB;
                        if (alu_zero) begin
                            st.pc_write = 1'b1;
                            st.pc_src   = PC_SKIP;
                        end
                    end
                    K_JUMP: begin
                        st.pc_write = 1'b1;
                        st.pc_src   = PC_JMP;
                    end
                    default: ;
                endcase
            end
            (state == S_MEM): begin
                st.iord      = 1'b1;
                st.mem_read  = (kind == K_LOAD);
                st.mem_write = (kind == K_STORE);
            end
            (state == S_WB): begin
                st.reg_write = 1'b1;
                if (kind == K_LOAD) begin
                    st.reg_dst    = 1'b0;
                    st.mem_to_reg = 1'b1;
                end else begin
                    st.reg_dst    = 1'b1;
                    st.mem_to_reg = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller.
// Holds state, latched opcode class, halt flag and retire counter.
module multicycle_control
    import isa_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    logic [2:0]       state_q, state_d;
    op_e              kind_q, kind_d;
    op_e              live_kind;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;
    logic             retire;
    strobes_t         dec_st, st;

    always_comb begin
        live_kind = K_ILL;
        if (bus.opcode <= OPCODE_W'(OP_JUMP))
            live_kind = op_e'(bus.opcode[2:0]);
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        halted_d = halted_q;
        retire   = 1'b0;
        unique case (1'b1)
            (state_q == S_FETCH): begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            (state_q == S_DECODE): begin
                kind_d = live_kind;
                if (live_kind == K_HALT) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                    retire   = 1'b1;
                end else if (live_kind == K_ILL) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            (state_q == S_EXEC): begin
                unique case (kind_q)
                    K_ADD, K_CLEAR:  state_d = S_WB;
                    K_LOAD, K_STORE: state_d = S_MEM;
                    default: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            (state_q == S_MEM): begin
                if (bus.mem_ready) begin
                    if (kind_q == K_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            (state_q == S_WB): begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            (state_q == S_HALTED): state_d = S_HALTED;
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            kind_q    <= K_ADD;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    ctrl_decode u_decode (
        .state     (state_q),
        .kind      (kind_q),
        .live_kind (live_kind),
        .alu_zero  (bus.alu_zero),
        .mem_ready (bus.mem_ready),
        .st        (dec_st)
    );

    // Reset overrides the map so an aborted access drops its strobe at once.
    assign st = reset ? '0 : dec_st;

    assign bus.PCWrite  = st.pc_write;
    assign bus.PCSrc    = st.pc_src;
    assign bus.IorD     = st.iord;
    assign bus.IRWrite  = st.ir_write;
    assign bus.RegDst   = st.reg_dst;
    assign bus.RegWrite = st.reg_write;
    assign bus.ALUSrc   = st.alu_src;
    assign bus.ALUOp    = st.alu_op;
    assign bus.MemRead  = st.mem_read;
    assign bus.MemWrite = st.mem_write;
    assign bus.MemToReg = st.mem_to_reg;
    assign bus.illegal  = st.illegal;
    assign bus.halted   = halted_q & ~reset;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Hand-timed instruction sequences plus a 4-bit counter wrap run.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    logic rst2;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(4), .CNT_W(16)) bus ();
    multicycle_control_if #(.OPCODE_W(4), .CNT_W(4))  bus2 ();

    multicycle_control #(.OPCODE_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicycle_control #(.OPCODE_W(4), .CNT_W(4)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected strobe word, field order matches strb().
    function automatic logic [13:0] s(
        input logic pcw, input logic [1:0] pcs, input logic iord,
        input logic irw, input logic rdst, input logic rw,
        input logic asrc, input logic [1:0] aop, input logic mr,
        input logic mw, input logic m2r, input logic ill);
        return {pcw, pcs, iord, irw, rdst, rw, asrc, aop, mr, mw, m2r, ill};
    endfunction

    function automatic logic [13:0] strb();
        return {bus.PCWrite, bus.PCSrc, bus.IorD, bus.IRWrite,
                bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.ALUOp,
                bus.MemRead, bus.MemWrite, bus.MemToReg, bus.illegal};
    endfunction

    task automatic t();
        @(negedge clk);
    endtask

    logic [13:0] F_DONE, F_WAIT, ZERO;

    initial begin
        F_DONE = s(1, 2'd0, 0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        F_WAIT = s(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
        ZERO   = '0;
        reset = 1'b1;
        rst2 = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 4'd0;
        bus.alu_zero = 1'b0;
        bus2.mem_ready = 1'b1;
        bus2.opcode = 4'd6;
        bus2.alu_zero = 1'b0;

        // reset held two cycles, then add
        t(); #1 chk("rst_c1", 32'(strb()), 32'(ZERO));
        t(); #1 chk("rst_c2", 32'(strb()), 32'(ZERO));
        chk("rst_ret", 32'(bus.retired), 0);
        t(); reset = 1'b0; #1 chk("add_fetch", 32'(strb()), 32'(F_DONE));
        t(); #1 chk("add_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("add_exec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("add_wb", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 0)));
        // load with three wait cycles in MEM
        t(); bus.opcode = 4'd2; #1 chk("ld_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_1", 32'(bus.retired), 1);
        t(); #1 chk("ld_dec", 32'(strb()), 32'(ZERO));
        t(); bus.mem_ready = 1'b0;
        #1 chk("ld_exec", 32'(strb()),
               32'(s(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) begin
            t(); bus.mem_ready = (i == 3);
            #1 chk("ld_mem", 32'(strb()),
                   32'(s(0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0)));
        end
        t(); #1 chk("ld_wb", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0)));
        // skip taken, with one fetch wait
        t(); bus.opcode = 4'd5; bus.mem_ready = 1'b0;
        #1 chk("sk_fwait", 32'(strb()), 32'(F_WAIT));
        chk("ret_2", 32'(bus.retired), 2);
        t(); bus.mem_ready = 1'b1; #1 chk("sk_fetch", 32'(strb()), 32'(F_DONE));
        t(); bus.alu_zero = 1'b1; #1 chk("sk_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("sk_taken", 32'(strb()),
                    32'(s(1, 2'd1, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0)));
        // skip not taken
        t(); bus.alu_zero = 1'b0; #1 chk("sk2_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_3", 32'(bus.retired), 3);
        t(); #1 chk("sk2_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("sk_not", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0)));
        // illegal opcode 9
        t(); bus.opcode = 4'd9; #1 chk("il_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_4", 32'(bus.retired), 4);
        t(); #1 chk("il_dec", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1)));
        // jump
        t(); bus.opcode = 4'd6; #1 chk("il_next", 32'(strb()), 32'(F_DONE));
        chk("ret_5", 32'(bus.retired), 5);
        t(); #1 chk("jp_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("jp_exec", 32'(strb()),
                    32'(s(1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)));
        // clear
        t(); bus.opcode = 4'd4; #1 chk("cl_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_6", 32'(bus.retired), 6);
        t(); #1 chk("cl_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("cl_exec", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 0)));
        t(); #1 chk("cl_wb", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 0)));
        // store, no waits
        t(); bus.opcode = 4'd3; #1 chk("st_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_7", 32'(bus.retired), 7);
        t(); #1 chk("st_dec", 32'(strb()), 32'(ZERO));
        t(); #1 chk("st_exec", 32'(strb()),
                    32'(s(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0)));
        t(); #1 chk("st_mem", 32'(strb()),
                    32'(s(0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0)));
        // store aborted by reset in MEM
        t(); #1 chk("st2_fetch", 32'(strb()), 32'(F_DONE));
        chk("ret_8", 32'(bus.retired), 8);
        t(); #1;
        t(); bus.mem_ready = 1'b0; #1;
        t(); #1 chk("st2_mem", 32'(strb()),
                    32'(s(0, 2'd0, 1, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0)));
        t(); reset = 1'b1; #1 chk("st2_rst", 32'(strb()), 32'(ZERO));
        t(); reset = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 4'd1;
        #1 chk("abort_fetch", 32'(strb()), 32'(F_DONE));
        chk("abort_ret", 32'(bus.retired), 0);
        // halt
        t(); #1 chk("h_dec", 32'(strb()), 32'(ZERO));
        chk("h_dec_flag", 32'(bus.halted), 0);
        for (int i = 0; i < 20; i++) begin
            t(); bus.mem_ready = i[0]; bus.opcode = 4'(i);
            #1 chk("h_strb", 32'(strb()), 32'(ZERO));
            chk("h_flag", 32'(bus.halted), 1);
        end
        chk("h_ret", 32'(bus.retired), 1);
        t(); reset = 1'b1; #1;
        t(); reset = 1'b0; bus.mem_ready = 1'b1; bus.opcode = 4'd0;
        #1 chk("h_rst_fetch", 32'(strb()), 32'(F_DONE));
        chk("h_rst_flag", 32'(bus.halted), 0);
        chk("h_rst_ret", 32'(bus.retired), 0);
        // 4-bit counter wraps after 16 jumps
        t(); rst2 = 1'b0;
        repeat (3) t();
        #1 chk("w_ret1", 32'(bus2.retired), 1);
        repeat (42) t();
        #1 chk("w_ret15", 32'(bus2.retired), 15);
        repeat (3) t();
        #1 chk("w_wrap", 32'(bus2.retired), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
